// File: rtl/sram_model_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_model_pkg
//  Description : Shared types and helpers for the 1RW SRAM model. Optional
//                spare column enabled by SRAM_SPARE_COL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_model_pkg;

    localparam int MAX_READ_LATENCY = 2;

`ifdef SRAM_SPARE_COL_EN
    localparam int c_SPARE_BITS = 1;
`else
    localparam int c_SPARE_BITS = 0;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    function automatic int lane_count(input int data_width, input int wmask_width);
        return data_width / wmask_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sram_rd_pipe
//  Description : Read-data delay line of LATENCY stages carrying {valid, data}.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_rd_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic             r_vld  [LATENCY];
    logic [WIDTH-1:0] r_data [LATENCY];

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        logic             w_vld_prev;
        logic [WIDTH-1:0] w_data_prev;

        if (k == 0) begin : g_head
            assign w_vld_prev  = i_vld;
            assign w_data_prev = i_data;
        end else begin : g_tail
            assign w_vld_prev  = r_vld[k-1];
            assign w_data_prev = r_data[k-1];
        end

        // Data only advances with a valid token so the last stage holds the
        // most recent read result between reads.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld[k]  <= 1'b0;
                r_data[k] <= '0;
            end else begin
                r_vld[k] <= w_vld_prev;
                if (w_vld_prev) begin
                    r_data[k] <= w_data_prev;
                end
            end
        end
    end

    assign o_vld  = r_vld[LATENCY-1];
    assign o_data = r_data[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/sram_1rw_wmask_model.sv
`default_nettype none
// ============================================================================
//  Module      : sram_1rw_wmask_model
//  Description : Behavioural 1RW SRAM with byte-lane write mask, range error
//                flag, read valid strobe and optional post-reset zero fill.
//                SRAM_SPARE_COL_EN adds a spare data column and spare_wen0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_1rw_wmask_model
    import sram_model_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int WMASK_WIDTH   = 8,
    parameter int WORDS         = 64,
    parameter int ADDR_WIDTH    = 6,
    parameter int READ_LATENCY  = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                                          clk0,
    input  logic                                          rst0,
    input  logic                                          csb0,
    input  logic                                          web0,
    input  logic [lane_count(DATA_WIDTH, WMASK_WIDTH)-1:0] wmask0,
`ifdef SRAM_SPARE_COL_EN
    input  logic                                          spare_wen0,
`endif
    input  logic [ADDR_WIDTH-1:0]                         addr0,
    input  logic [DATA_WIDTH+c_SPARE_BITS-1:0]            din0,
    output logic [DATA_WIDTH+c_SPARE_BITS-1:0]            dout0,
    output logic                                          dout_valid0,
    output logic                                          busy0,
    output logic                                          addr_err0
);

    localparam int                    c_LANES = lane_count(DATA_WIDTH, WMASK_WIDTH);
    localparam int                    c_DW    = DATA_WIDTH + c_SPARE_BITS;
    localparam logic [ADDR_WIDTH:0]   c_WORDS = (ADDR_WIDTH + 1)'(WORDS);
    localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(WORDS - 1);

    if (WMASK_WIDTH < 1 || (DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_chk_lanes
        $error("DATA_WIDTH must be a non-zero multiple of WMASK_WIDTH");
    end
    if (WORDS < 1 || WORDS > (1 << ADDR_WIDTH)) begin : g_chk_depth
        $error("WORDS must be in 1..2**ADDR_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_chk_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    if (INIT_ON_RESET != 0 && INIT_ON_RESET != 1) begin : g_chk_init
        $error("INIT_ON_RESET must be 0 or 1");
    end

    logic [c_DW-1:0]       r_mem [WORDS];
    fill_state_e           r_state;
    fill_state_e           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_fill_cnt;
    logic [ADDR_WIDTH-1:0] w_fill_cnt_nxt;
    logic                  r_addr_err;
    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_fill_we;
    logic [c_DW-1:0]       w_rd_data;

    assign busy0      = (r_state == FILL);
    assign w_accept   = !csb0 && !busy0 && !rst0;
    assign w_in_range = ({1'b0, addr0} < c_WORDS);
    assign w_fill_we  = busy0 && !rst0;
    assign w_rd_data  = w_in_range ? r_mem[addr0] : '0;
    assign addr_err0  = r_addr_err;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state    <= (INIT_ON_RESET != 0) ? FILL : IDLE;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        case (r_state)
            FILL: begin
                w_fill_cnt_nxt = r_fill_cnt + 1'b1;
                if (r_fill_cnt == c_LAST) begin
                    w_state_nxt    = IDLE;
                    w_fill_cnt_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    // Array has no reset; only the fill sequencer clears it.
    always_ff @(posedge clk0) begin
        if (w_fill_we) begin
            r_mem[r_fill_cnt] <= '0;
        end else if (w_accept && !web0 && w_in_range) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (wmask0[i]) begin
                    r_mem[addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= din0[i*WMASK_WIDTH +: WMASK_WIDTH];
                end
            end
`ifdef SRAM_SPARE_COL_EN
            if (spare_wen0) begin
                r_mem[addr0][DATA_WIDTH] <= din0[DATA_WIDTH];
            end
`endif
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_accept && !w_in_range;
        end
    end

    sram_rd_pipe #(
        .WIDTH   (c_DW),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk    (clk0),
        .rst    (rst0),
        .i_vld  (w_accept && web0),
        .i_data (w_rd_data),
        .o_vld  (dout_valid0),
        .o_data (dout0)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw_wmask_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_1rw_wmask_model
//  Description : Two SRAM instances (64 words / latency 1, 48 words / latency 2)
//                on shared stimulus, checked against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_1rw_wmask_model;

    localparam int NL = 4;
`ifdef SRAM_SPARE_COL_EN
    localparam int DW = 33;
`else
    localparam int DW = 32;
`endif
    localparam int WORDS_T [2] = '{64, 48};
    localparam int LAT_T   [2] = '{1, 2};

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst0;
    logic          csb0;
    logic          web0;
    logic [NL-1:0] wmask0;
    logic [5:0]    addr0;
    logic [DW-1:0] din0;
`ifdef SRAM_SPARE_COL_EN
    logic          spare_wen0;
`endif
    logic [DW-1:0] dout   [2];
    logic          dval   [2];
    logic          busy   [2];
    logic          aerr   [2];

    int            edge_cnt = 0;
    int            last_rst = -1000;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] mem      [2][64];
    logic [DW-1:0] exp_last [2];
    rd_t           rdq      [2][$];
    int            errq     [2][$];

    sram_1rw_wmask_model #(
        .WORDS(64), .ADDR_WIDTH(6), .READ_LATENCY(1), .INIT_ON_RESET(1)
    ) u_dut0 (
        .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
`ifdef SRAM_SPARE_COL_EN
        .spare_wen0(spare_wen0),
`endif
        .addr0(addr0), .din0(din0), .dout0(dout[0]), .dout_valid0(dval[0]),
        .busy0(busy[0]), .addr_err0(aerr[0])
    );

    sram_1rw_wmask_model #(
        .WORDS(48), .ADDR_WIDTH(6), .READ_LATENCY(2), .INIT_ON_RESET(1)
    ) u_dut1 (
        .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
`ifdef SRAM_SPARE_COL_EN
        .spare_wen0(spare_wen0),
`endif
        .addr0(addr0), .din0(din0), .dout0(dout[1]), .dout_valid0(dval[1]),
        .busy0(busy[1]), .addr_err0(aerr[1])
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (rst0) last_rst <= edge_cnt + 1;
    end

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %h expected %h at edge %0d", name, idx, act, exp, edge_cnt);
        end
    endtask

    // Monitor: one pass per cycle, away from the active edge.
    always @(negedge clk) begin
        logic ev;
        logic ee;
        if (last_rst > 0) begin
            for (int i = 0; i < 2; i++) begin
                if (last_rst == edge_cnt) exp_last[i] = '0;
                chk("busy0", i, 64'(busy[i]), 64'(edge_cnt < last_rst + WORDS_T[i]));
                ee = (errq[i].size() > 0) && (errq[i][0] == edge_cnt);
                if (ee) void'(errq[i].pop_front());
                chk("addr_err0", i, 64'(aerr[i]), 64'(ee));
                ev = (rdq[i].size() > 0) && (rdq[i][0].due == edge_cnt);
                chk("dout_valid0", i, 64'(dval[i]), 64'(ev));
                if (ev) begin
                    chk("read_data", i, 64'(dout[i]), 64'(rdq[i][0].data));
                    exp_last[i] = rdq[i][0].data;
                    void'(rdq[i].pop_front());
                end else begin
                    chk("dout_hold", i, 64'(dout[i]), 64'(exp_last[i]));
                end
            end
        end
    end

    task automatic idle(input int k);
        csb0 = 1'b1;
        repeat (k) @(negedge clk);
    endtask

    // Reset at the next edge discards every response not yet presented.
    task automatic do_reset(input int k);
        int n = edge_cnt;
        rst0 = 1'b1;
        csb0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            while (rdq[i].size() > 0 && rdq[i][$].due > n) void'(rdq[i].pop_back());
            while (errq[i].size() > 0 && errq[i][$] > n) void'(errq[i].pop_back());
            for (int a = 0; a < 64; a++) mem[i][a] = '0;
        end
        repeat (k) @(negedge clk);
        rst0 = 1'b0;
    endtask

    task automatic issue(input logic we_n, input logic [NL-1:0] m, input logic [5:0] a,
                         input logic [DW-1:0] d, input logic sw);
        int n = edge_cnt;
        csb0 = 1'b0; web0 = we_n; wmask0 = m; addr0 = a; din0 = d;
`ifdef SRAM_SPARE_COL_EN
        spare_wen0 = sw;
`endif
        for (int i = 0; i < 2; i++) begin
            if (!rst0 && n >= last_rst + WORDS_T[i]) begin
                if (int'(a) >= WORDS_T[i]) errq[i].push_back(n + 1);
                if (we_n) begin
                    rd_t r;
                    r.due  = n + LAT_T[i];
                    r.data = (int'(a) < WORDS_T[i]) ? mem[i][a] : '0;
                    rdq[i].push_back(r);
                end else if (int'(a) < WORDS_T[i]) begin
                    for (int l = 0; l < NL; l++)
                        if (m[l]) mem[i][a][l*8 +: 8] = d[l*8 +: 8];
`ifdef SRAM_SPARE_COL_EN
                    if (sw) mem[i][a][DW-1] = d[DW-1];
`endif
                end
            end
        end
        @(negedge clk);
        csb0 = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom()});
    endfunction

    initial begin
        rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
`ifdef SRAM_SPARE_COL_EN
        spare_wen0 = 1'b0;
`endif
        exp_last[0] = '0; exp_last[1] = '0;
        do_reset(3);
        issue(1'b0, 4'hF, 6'd2, DW'(32'h5555AAAA), 1'b0);  // dropped while filling
        idle(70);

        for (int a = 0; a < 64; a++) issue(1'b1, 4'h0, 6'(a), '0, 1'b0);
        idle(3);

        issue(1'b0, 4'b1111, 6'd5, DW'(32'hFFFFFFFF), 1'b0);
        issue(1'b0, 4'b0101, 6'd5, DW'(32'h12345678), 1'b0);
        issue(1'b1, 4'h0, 6'd5, '0, 1'b0);
        issue(1'b0, 4'b0000, 6'd5, DW'(32'h0BADF00D), 1'b0);
        issue(1'b1, 4'h0, 6'd5, '0, 1'b0);
        idle(3);

        for (int a = 0; a < 8; a++) issue(1'b0, 4'hF, 6'(a), DW'(a), 1'b0);
        for (int a = 0; a < 8; a++) issue(1'b1, 4'h0, 6'(a), '0, 1'b0);
        idle(4);

        issue(1'b0, 4'hF, 6'd50, DW'(32'hDEADBEEF), 1'b0);
        issue(1'b1, 4'h0, 6'd50, '0, 1'b0);
        issue(1'b1, 4'h0, 6'd47, '0, 1'b0);
        issue(1'b1, 4'h0, 6'd48, '0, 1'b0);
        issue(1'b0, 4'hF, 6'd63, DW'(32'hCAFEF00D), 1'b0);
        issue(1'b1, 4'h0, 6'd63, '0, 1'b0);
        idle(4);

`ifdef SRAM_SPARE_COL_EN
        issue(1'b0, 4'h0, 6'd9, {1'b1, 32'hFFFFFFFF}, 1'b1);
        issue(1'b1, 4'h0, 6'd9, '0, 1'b0);
        issue(1'b0, 4'h0, 6'd9, {1'b0, 32'h0}, 1'b0);
        issue(1'b1, 4'h0, 6'd9, '0, 1'b0);
        idle(4);
`endif

        do_reset(2);
        idle(20);
        do_reset(1);
        idle(70);

        issue(1'b0, 4'hF, 6'd3, DW'(32'h01020304), 1'b0);
        issue(1'b1, 4'h0, 6'd3, '0, 1'b0);
        do_reset(1);
        idle(70);

        for (int k = 0; k < 3000; k++) begin
            int r = int'($urandom_range(0, 999));
            if (r < 3)        do_reset(int'($urandom_range(1, 3)));
            else if (r < 250) idle(1);
            else issue(1'($urandom_range(0, 1)), NL'($urandom()), 6'($urandom_range(0, 63)),
                       rnd_data(), 1'($urandom_range(0, 1)));
        end
        idle(6);

        for (int i = 0; i < 2; i++) begin
            chk("read_queue_drained", i, 64'(rdq[i].size()), 64'd0);
            chk("err_queue_drained", i, 64'(errq[i].size()), 64'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
